// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Definitions shared by the sequential binary-to-BCD converter:
//   - state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   - DIGIT_MINUS : digit code the display driver shows as a minus sign
//   - DIGIT_BLANK : digit code the display driver shows as a dark digit
//   - req_digits  : number of BCD digits a WIDTH-bit input needs, counting
//                   the sign/top digit, used for elaboration checks
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // ceil(width * log10(2)) magnitude digits plus one sign digit.
  // log10(2) is approximated as 0.30103 in fixed point.
  function automatic int req_digits(input int width);
    return (width * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adjust.sv
// ---------------------------------------------------------------------------
// dd_adjust_digit
//   Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
//   that the following left shift carries correctly into the next digit.
//   Ports:
//     din  in  4  BCD digit before correction
//     dout out 4  corrected digit
// ---------------------------------------------------------------------------
module dd_adjust_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Multi-cycle binary-to-BCD converter (shift-and-add-3) with a valid/ready
//   input handshake. Feeds the 4-digit seven-segment driver; bcd_out is held
//   between conversions so the display never shows a partial result.
//   Latency: accept at edge k, result and out_valid visible after edge
//   k+WIDTH+1. One conversion per WIDTH+2 cycles.
//
//   Build option: define BIN2BCD_SIGNED_EN to treat in_data as two's
//   complement; negative inputs convert their magnitude and the top digit
//   of bcd_out becomes DIGIT_MINUS. Without it the top digit is always 0.
//
//   Ports:
//     clk       in   1         system clock, rising edge
//     rst       in   1         asynchronous reset, active-high
//     in_valid  in   1         in_data is presented for conversion
//     in_ready  out  1         converter idle; accepts when in_valid is high
//     in_data   in   WIDTH     binary value to convert
//     out_valid out  1         one-cycle pulse: bcd_out has just been updated
//     bcd_out   out  4*DIGITS  packed BCD, digit i in [4i+3:4i]
//     busy      out  1         conversion in progress (!in_ready)
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int BCD_W = 4 * (DIGITS - 1);   // magnitude digits only
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (DIGITS < req_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH (magnitude + sign digit)");
  end
  // The driver must be able to tell a minus sign from a dark digit.
  if (DIGIT_MINUS == DIGIT_BLANK) begin : g_code_check
    $error("bin2bcd_seq: minus and blank digit codes collide");
  end

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    logic signed [WIDTH-1:0] sv;
    sv = v;
    // Negation kept WIDTH bits wide and read as unsigned, so the most
    // negative value maps to its true magnitude (e.g. -128 -> 128).
    magnitude = (sv < 0) ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
`else
    magnitude = v;
`endif
  endfunction

  function automatic logic is_negative(input logic [WIDTH-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    is_negative = v[WIDTH-1];
`else
    is_negative = 1'b0 & v[WIDTH-1];
`endif
  endfunction

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic             out_valid_q;

  // Digit corrections ahead of the shift; the sign digit lives outside the
  // shift register and is never adjusted.
  for (genvar i = 0; i < DIGITS - 1; i++) begin : g_adj
    dd_adjust_digit u_adj (
      .din  (sr_q[WIDTH + 4*i +: 4]),
      .dout (sr_adj[WIDTH + 4*i +: 4])
    );
  end
  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, adjust+shift while in SHIFT, publish in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q   <= {{BCD_W{1'b0}}, magnitude(in_data)};
            cnt_q  <= CNT_W'(WIDTH);
            sign_q <= is_negative(in_data);
          end
        end
        SHIFT: begin
          sr_q  <= sr_adj << 1;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bcd_q <= {(sign_q ? DIGIT_MINUS : 4'h0), sr_q[SR_W-1 -: BCD_W]};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=4). Works in either
//   build; expectations follow BIN2BCD_SIGNED_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal digits from plain arithmetic.
  function automatic logic [15:0] ref_bcd(input logic [7:0] d);
    int v;
    logic [15:0] r;
    v = int'(d);
    r = '0;
`ifdef BIN2BCD_SIGNED_EN
    if (d[7]) begin
      v = 256 - v;
      r[15:12] = 4'hA;
    end
`endif
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'(v / 100);
    return r;
  endfunction

  // One request from idle; checks handshake, latency, holding and result.
  task automatic convert(input logic [7:0] d, input logic [15:0] exp,
                         input logic [15:0] hold, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    check({nm, " ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check({nm, " ready_drop"}, 32'(in_ready), 32'd0);
    check({nm, " busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 40) begin
      check({nm, " hold"}, 32'(bcd_out), 32'(hold));
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'd9);
    check({nm, " result"}, 32'(bcd_out), 32'(exp));
    check({nm, " ready_at_done"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    check({nm, " pulse_width"}, 32'(out_valid), 32'd0);
    check({nm, " ready_after"}, 32'(in_ready), 32'd1);
    check({nm, " held"}, 32'(bcd_out), 32'(exp));
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [15:0] last;
    logic [15:0] exp_q[$];
    int pulses;
    int sweep_n;
    int pushed;
    int last_ov;
    int guard;

`ifdef BIN2BCD_SIGNED_EN
    vecs[0] = '{8'h80, 16'hA128};
    vecs[1] = '{8'h7F, 16'h0127};
    vecs[2] = '{8'hFF, 16'hA001};
    vecs[3] = '{8'h00, 16'h0000};
    vecs[4] = '{8'h9C, 16'hA100};
    vecs[5] = '{8'h0A, 16'h0010};
    vecs[6] = '{8'h63, 16'h0099};
`else
    vecs[0] = '{8'd255, 16'h0255};
    vecs[1] = '{8'd99,  16'h0099};
    vecs[2] = '{8'h80,  16'h0128};
    vecs[3] = '{8'd0,   16'h0000};
    vecs[4] = '{8'd100, 16'h0100};
    vecs[5] = '{8'd10,  16'h0010};
    vecs[6] = '{8'd1,   16'h0001};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst bcd_out", 32'(bcd_out), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;

    convert(8'd0, 16'h0000, 16'h0000, "zero");
    last = 16'h0000;

    for (int i = 0; i < 7; i++) begin
      convert(vecs[i].din, vecs[i].exp, last, $sformatf("vec%0d", i));
      last = vecs[i].exp;
    end

    // Requests during a conversion are ignored, not queued.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd200;
    @(negedge clk);
    in_data = 8'd37;
    pulses = 0;
    for (int j = 0; j < 9; j++) begin
      check("ign ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ign out_valid", 32'(out_valid), 32'd1);
    check("ign result", 32'(bcd_out), 32'(ref_bcd(8'd200)));
    last = ref_bcd(8'd200);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("ign extra_pulses", 32'(pulses), 32'd0);

    // Asynchronous reset mid-conversion aborts without a result.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd123;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort bcd_out", 32'(bcd_out), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort no_pulse", 32'(pulses), 32'd0);
    convert(8'd45, ref_bcd(8'd45), 16'h0000, "post_abort");

    // in_valid held high: sweep 0..255 then random values, data scrambled
    // whenever the converter is busy.
    sweep_n = 256 + 40;
    pushed  = 0;
    last_ov = -1;
    guard   = 0;
    @(negedge clk);
    while ((pushed < sweep_n || exp_q.size() > 0) && guard < 5000) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sweep unexpected_pulse", 32'd1, 32'd0);
        end else begin
          check("sweep result", 32'(bcd_out), 32'(exp_q.pop_front()));
        end
        if (last_ov >= 0) check("sweep spacing", 32'(cyc - last_ov), 32'd10);
        last_ov = cyc;
      end
      if (in_ready && pushed < sweep_n) begin
        in_valid = 1'b1;
        in_data  = (pushed < 256) ? 8'(pushed) : 8'($urandom);
        exp_q.push_back(ref_bcd(in_data));
        pushed++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        in_data = 8'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("sweep completed", 32'(guard < 5000), 32'd1);
    check("sweep all_accepted", 32'(pushed), 32'(sweep_n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
